// File: rtl/clk_en_gen_if.sv
// clk_en_gen_if: configuration inputs and clock-enable outputs of the fractional clock-enable generator.
interface clk_en_gen_if #(
  parameter int CHANNELS = 2,
  parameter int ACC_W = 32
);
  logic [CHANNELS*ACC_W-1:0] inc;
  logic load;
  logic [CHANNELS-1:0] ch_en;
  logic [CHANNELS-1:0] outclk_en;
  logic [CHANNELS-1:0] outclk_sq;
  logic locked;
  modport master(output inc, load, ch_en, input outclk_en, outclk_sq, locked);
  modport slave(input inc, load, ch_en, output outclk_en, outclk_sq, locked);
endinterface

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel NCO clock-enable generator with settle/lock sequencing.
module clk_en_gen #(
  parameter int CHANNELS = 2,
  parameter int ACC_W = 32,
  parameter int SETTLE = 16,
  parameter logic [CHANNELS*ACC_W-1:0] INC_RST = '0
) (
  input logic refclk_i,
  input logic rst_n_i,
  clk_en_gen_if.slave bus
);
  localparam int CNT_W = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic {ST_SETTLE, ST_RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][ACC_W-1:0] inc_q, inc_d, acc_q, acc_d;
  logic [CHANNELS-1:0][ACC_W:0] sum;
  logic [CHANNELS-1:0] en_q, en_d, sq_q, sq_d;
  logic locked_q, locked_d;
  // carry out of the full-width sum is the enable pulse
  for (genvar c = 0; c < CHANNELS; c++) begin : g_sum
    assign sum[c] = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    locked_d = locked_q;
    inc_d = inc_q;
    acc_d = acc_q;
    en_d = '0;
    sq_d = sq_q;
    if (bus.load) begin
      state_d = ST_SETTLE;
      cnt_d = '0;
      locked_d = 1'b0;
      inc_d = bus.inc;
      acc_d = '0;
      sq_d = '0;
    end else if (state_q == ST_SETTLE) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = '0;
      sq_d = '0;
      if (cnt_q == CNT_W'(SETTLE - 1)) begin
        state_d = ST_RUN;
        locked_d = 1'b1;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.ch_en[i]) begin
          acc_d[i] = sum[i][ACC_W-1:0];
          en_d[i] = sum[i][ACC_W];
          sq_d[i] = sum[i][ACC_W-1];
        end
      end
    end
  end
  always_ff @(posedge refclk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_SETTLE;
      cnt_q <= '0;
      locked_q <= 1'b0;
      inc_q <= INC_RST;
      acc_q <= '0;
      en_q <= '0;
      sq_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      locked_q <= locked_d;
      inc_q <= inc_d;
      acc_q <= acc_d;
      en_q <= en_d;
      sq_q <= sq_d;
    end
  end
  assign bus.outclk_en = en_q;
  assign bus.outclk_sq = sq_q;
  assign bus.locked = locked_q;
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: scoreboard bench; reference model counts enabled cycles and derives phase as n*inc mod 2^W.
module tb_clk_en_gen;
  localparam int CH = 2;
  localparam int W = 32;
  localparam int ST = 16;
  typedef struct packed {
    logic [CH-1:0] en;
    logic [CH-1:0] sq;
    logic lk;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  clk_en_gen_if #(.CHANNELS(CH), .ACC_W(W)) bus();
  clk_en_gen #(.CHANNELS(CH), .ACC_W(W), .SETTLE(ST), .INC_RST('0)) dut (
    .refclk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus)
  );
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  longint unsigned m_inc[CH];
  longint unsigned m_n[CH];
  int m_since = 0;
  task automatic step();
    exp_t e;
    longint unsigned a, b;
    e = '0;
    if (!rst_n || bus.load) begin
      m_since = 0;
      for (int c = 0; c < CH; c++) begin
        m_inc[c] = rst_n ? {32'h0, bus.inc[c*W +: W]} : 64'd0;
        m_n[c] = 0;
      end
    end else if (m_since < ST) begin
      m_since++;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (bus.ch_en[c]) begin
          a = m_n[c] * m_inc[c];
          b = (m_n[c] + 1) * m_inc[c];
          e.en[c] = (a >> W) != (b >> W);
          m_n[c]++;
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      a = m_n[c] * m_inc[c];
      e.sq[c] = a[W-1];
    end
    e.lk = m_since == ST;
    q.push_back(e);
  endtask
  task automatic cyc(input logic r, input logic ld, input logic [CH*W-1:0] inc, input logic [CH-1:0] en);
    @(negedge clk);
    rst_n = r;
    bus.load = ld;
    bus.inc = inc;
    bus.ch_en = en;
    step();
  endtask
  function automatic logic [W-1:0] pick();
    int s;
    logic [W-1:0] v;
    s = $urandom_range(0, 4);
    v = (s == 0) ? 32'h0 : (s == 1) ? 32'hFFFF_FFFF : (s == 2) ? 32'h4000_0000 : (s == 3) ? 32'($urandom()) : 32'($urandom_range(1, 1000));
    return v;
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.outclk_en, bus.outclk_sq, bus.locked} !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got en=%b sq=%b lk=%b want en=%b sq=%b lk=%b",
                   $time, bus.outclk_en, bus.outclk_sq, bus.locked, e.en, e.sq, e.lk);
        end
      end
    end
  end
  initial begin
    logic [CH*W-1:0] inc2;
    int first0, first1, cnt, adj;
    logic prev;
    bus.load = 1'b0;
    bus.inc = '0;
    bus.ch_en = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 2'b11);
    for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, '0, 2'($urandom_range(0, 3)));
    inc2 = {32'h2000_0000, 32'h4000_0000};
    cyc(1'b1, 1'b1, inc2, 2'b11);
    for (int i = 0; i < ST; i++) cyc(1'b1, 1'b0, '0, 2'b11);
    first0 = -1;
    first1 = -1;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b0, '0, (k >= 20 && k < 23) ? 2'b10 : 2'b11);
      if (bus.outclk_en[0] && first0 < 0) first0 = k;
      if (bus.outclk_en[1] && first1 < 0) first1 = k;
    end
    checks++;
    if (first0 != 4) begin
      errors++;
      $display("FAIL first_pulse_ch0 got %0d want 4", first0);
    end
    checks++;
    if (first1 != 8) begin
      errors++;
      $display("FAIL first_pulse_ch1 got %0d want 8", first1);
    end
    cyc(1'b1, 1'b1, inc2, 2'b11);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0, 2'b11);
    cyc(1'b1, 1'b1, {32'h1000_0000, 32'h4000_0000}, 2'b11);
    for (int i = 0; i < ST + 20; i++) cyc(1'b1, 1'b0, '0, 2'b11);
    cyc(1'b0, 1'b1, {pick(), 32'hFFFF_FFFF}, 2'b11);
    for (int i = 0; i < ST + 20; i++) cyc(1'b1, 1'b0, '0, 2'b11);
    cyc(1'b1, 1'b1, {pick(), 32'd1232814614}, 2'b11);
    for (int i = 0; i < ST; i++) cyc(1'b1, 1'b0, '0, 2'b11);
    cnt = 0;
    adj = 0;
    prev = 1'b0;
    for (int k = 0; k < 50000; k++) begin
      cyc(1'b1, 1'b0, '0, 2'b11);
      if (bus.outclk_en[0]) cnt++;
      if (bus.outclk_en[0] && prev) adj++;
      prev = bus.outclk_en[0];
    end
    checks++;
    if (cnt != 14351 && cnt != 14352) begin
      errors++;
      $display("FAIL pulse_count got %0d want 14351 or 14352", cnt);
    end
    checks++;
    if (adj != 0) begin
      errors++;
      $display("FAIL adjacent_pulses got %0d want 0", adj);
    end
    for (int k = 0; k < 3000; k++) begin
      cyc(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 39) == 0), {pick(), pick()},
          {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
    end
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
